joker_spi_arb: RTL and testbench
================================

# joker_spi_arb

Two-port Wishbone arbiter that shares the single SPI master core (`spi_top`, flash pins) between the USB command path (port 0) and a second on-chip requester such as a flash status poller or config reader (port 1). It grants one requester at a time with round-robin fairness. A `lock` input lets the owner keep the core across several Wishbone cycles, so chip-select framing (SS set, N× TX/CTRL/RX, SS clear) is never interleaved. A watchdog aborts a cycle the core never acknowledges.

## Interface
- `TIMEOUT`, default 4095: cycles `s_stb` may stay high without `s_ack` before abort; counter width is `$clog2(TIMEOUT+1)`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mN_cyc`, `mN_stb`, `mN_we` in 1 each (N = 0, 1): requester Wishbone controls.
- `mN_adr` in 5: SPI core register address.
- `mN_dat_i` in 32: requester write data.
- `mN_sel` in 4: byte selects.
- `mN_lock` in 1: keep the grant after `mN_cyc` falls.
- `mN_ack` out 1: acknowledge, routed only to the granted port.
- `mN_err` out 1: core error or watchdog abort, routed only to the granted port.
- `mN_dat_o` out 32: read data, equal to `s_dat_i` and valid only with `mN_ack`.
- `s_cyc`, `s_stb`, `s_we` out 1 each: to the SPI core.
- `s_adr` out 5, `s_dat_o` out 32, `s_sel` out 4: to the SPI core.
- `s_ack`, `s_err` in 1 each: from the SPI core.
- `s_dat_i` in 32: core read data.
- `grant` out 2: one-hot owner; 00 means idle.
- `busy` out 1: high whenever `grant` is non-zero.

## Operation
- States:
  - IDLE: `grant` = 00; all `s_*` outputs driven 0.
  - OWN0 / OWN1: the slave bus carries the owner's signals.
  - ABORT: after a watchdog fire.
- Arbitration happens in IDLE only:
  - One `mN_cyc` high: move to OWNN.
  - Both high: grant the port that was not granted last (`last` register). `last` resets to 1, so port 0 wins the first tie.
  - `last` updates on entry to OWNN.
- In OWNN:
  - `s_cyc`/`s_stb`/`s_we`/`s_adr`/`s_dat_o`/`s_sel` follow port N combinationally.
  - `mN_ack` = `s_ack`; `mN_err` = `s_err`.
  - The other port sees `ack`/`err` = 0, and its `stb` is ignored. It waits with `cyc` held.
- Release: in OWNN, when `mN_cyc` = 0 and `mN_lock` = 0 are sampled, go to IDLE next cycle.
  - `lock` = 1 with `cyc` = 0 keeps OWNN indefinitely; this is the owner's responsibility.
- Watchdog:
  - Counter clears on any cycle where `s_stb` = 0 or `s_ack` = 1, and increments otherwise.
  - When it reaches `TIMEOUT`: `mN_err` pulses one cycle (registered), and the state becomes ABORT.
  - ABORT drives the `s_*` outputs 0 and ignores `s_ack`. It returns to IDLE once `mN_cyc` = 0, regardless of `lock`.
- `s_err` during OWNN passes through and does not abort.
- Reset mid-transaction: next cycle is IDLE with `s_cyc`/`s_stb` = 0, `grant` = 00, `last` = 1, counter 0.
  - The SPI core shares `reset`, so no partial core state survives.

## Timing
- Reset values: all `s_*` = 0, `mN_ack`/`mN_err` = 0, `grant` = 00, `busy` = 0. `mN_dat_o` mirrors `s_dat_i`.
- Grant latency: `mN_cyc` rises in cycle t, then `grant` and `s_cyc`/`s_stb` are high in cycle t+1.
- Ack path is combinational: `mN_ack` is high in the same cycle as `s_ack`. The requester drops `stb` on ack, as with the SPI core today.
- Release: `cyc` and `lock` low sampled at cycle t, so IDLE at t+1 and earliest new grant at t+2. This guarantees at least one idle bus cycle between owners.
- Watchdog: `s_stb` high from cycle t with no ack, so `mN_err` is high in cycle t+TIMEOUT and `s_stb` is 0 from t+TIMEOUT+1.
- Same-cycle events:
  - A request on the idle port while the owner releases is granted at t+2.
  - `s_ack` on the same cycle the counter would hit `TIMEOUT` wins: no err, counter clears.

## Test plan
- Single requester: m0 writes `SPI_DEVIDE` = 0x00 then reads `SPI_CTRL` → `grant` = 01 one cycle after `cyc`; `s_adr`/`s_dat_o`/`s_sel` equal m0's values; `m0_ack` pulses; `m1_ack` stays 0.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle → `grant` = 01 first. After m0 releases, `grant` = 10 exactly 2 cycles later. On the next tie, `grant` = 01 again (round-robin).
- Lock framing: m0 holds `lock` across SS=1, TX=0xA5, CTRL GO, CTRL poll ×3, RX, SS=0, dropping `cyc` between cycles; m1 requests throughout → m1 is never granted until m0 drops `lock`; no m1 address appears on `s_adr` inside the frame.
- Watchdog: `TIMEOUT` = 16; a slave stub never acks m1 → `m1_err` is high exactly 16 cycles after `s_stb` rises; `s_stb` = 0 next cycle; IDLE after `m1_cyc` drops; a subsequent m0 request is granted.
- Reset mid-cycle: assert `reset` for 1 cycle while OWN1 with `s_stb` = 1 → next cycle `s_cyc` = 0, `grant` = 00; a following tie grants m0.
- Error pass-through: slave stub returns `s_err` on an m0 read → `m0_err` = 1 in the same cycle, `grant` stays 01, no ABORT.

Source files
------------

// File: rtl/joker_spi_arb_if.sv
// Wishbone link used between the SPI arbiter, its two requesters and the SPI core.
//
// Handshake: a beat is offered while cyc && stb are high, and the request
// fields (we, adr, dat_w, sel) stay stable until the responder ends that beat
// by raising ack (or err) for exactly one cycle, combinationally with stb.
// dat_r carries read data and means something only in the ack cycle. lock is
// a requester-side hint that asks the arbiter to keep this link's grant after
// cyc falls.
interface joker_spi_arb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        lock;
  logic [4:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;

  // Requester side: drives the beat and lock, receives the response.
  modport master (
    output cyc, stb, we, lock, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  // Responder side: receives the beat and lock, drives the response.
  modport slave (
    input  cyc, stb, we, lock, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/joker_spi_arb.sv
// Two-port round-robin Wishbone arbiter in front of the shared SPI master core.
// Port 0 is the USB command path, port 1 an on-chip requester. The owner may
// hold the core across several Wishbone cycles with lock so a chip-select
// frame is never interleaved, and a watchdog aborts a beat the core never
// acknowledges.
module joker_spi_arb #(
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             reset,
  joker_spi_arb_if.slave   m0,
  joker_spi_arb_if.slave   m1,
  joker_spi_arb_if.master  s,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  // Port granted most recently; in OWN/ABORT it is also the current owner.
  logic             last;
  logic             last_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_nxt;
  logic             wd_fire;
  logic             own_cyc;

  // The counter only ever reaches TIMEOUT in the cycle it fires, so the
  // compare is itself the registered one-cycle abort pulse.
  assign wd_fire = (wd_cnt == CNT_W'(TIMEOUT));
  assign own_cyc = last ? m1.cyc : m0.cyc;

  // State, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Next state: arbitrate only from IDLE, release on cyc and lock both low,
  // abort on watchdog, and leave ABORT once the owner drops cyc.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          if (last) begin
            state_nxt = ST_OWN0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = ST_OWN1;
            last_nxt  = 1'b1;
          end
        end else if (m0.cyc) begin
          state_nxt = ST_OWN0;
          last_nxt  = 1'b0;
        end else if (m1.cyc) begin
          state_nxt = ST_OWN1;
          last_nxt  = 1'b1;
        end
      end
      ST_OWN0: begin
        if (wd_fire) begin
          state_nxt = ST_ABORT;
        end else if (!m0.cyc && !m0.lock) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (wd_fire) begin
          state_nxt = ST_ABORT;
        end else if (!m1.cyc && !m1.lock) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: begin
        // lock is deliberately ignored here: an aborted owner must let go.
        if (!own_cyc) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog: counts consecutive cycles with stb high and no ack; an ack in
  // the cycle it would reach TIMEOUT clears it first.
  always_comb begin
    wd_cnt_nxt = wd_cnt + CNT_W'(1);
    if (wd_fire || !s.stb || s.ack) begin
      wd_cnt_nxt = '0;
    end
  end

  // Slave bus mux: the owner's beat passes straight through, else all zero.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    unique case (state)
      ST_OWN0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
      end
      ST_OWN1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
      end
      default: ;
    endcase
  end

  // The core has no notion of bus locking.
  assign s.lock = 1'b0;

  // Responses reach only the owner; read data is broadcast and qualified by ack.
  always_comb begin
    m0.ack = 1'b0;
    m0.err = 1'b0;
    m1.ack = 1'b0;
    m1.err = 1'b0;
    if (state == ST_OWN0) begin
      m0.ack = s.ack;
      m0.err = s.err | wd_fire;
    end
    if (state == ST_OWN1) begin
      m1.ack = s.ack;
      m1.err = s.err | wd_fire;
    end
  end

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  // One-hot owner view; an aborted owner still holds the core until it lets go.
  always_comb begin
    grant = 2'b00;
    unique case (state)
      ST_OWN0:  grant = 2'b01;
      ST_OWN1:  grant = 2'b10;
      ST_ABORT: grant = last ? 2'b10 : 2'b01;
      default:  grant = 2'b00;
    endcase
  end

  assign busy      = |grant;
  assign dbg_state = state;

endmodule

// File: tb/tb_joker_spi_arb.sv
// Bench for joker_spi_arb: directed timing scenarios plus randomized rounds.
// Drivers push each expected slave-bus beat (owner port + request fields)
// into exp_q in the order the arbitration rules dictate; a monitor pops and
// compares whenever the core ends a beat with ack or err.
module tb_joker_spi_arb;

  localparam int TO = 16;
  localparam int EW = 43;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] dbg_state;

  joker_spi_arb_if m0_if ();
  joker_spi_arb_if m1_if ();
  joker_spi_arb_if s_if ();

  joker_spi_arb #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant     (grant),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- requester and stub drive ----------------
  logic        req_cyc [2];
  logic        req_stb [2];
  logic        req_we  [2];
  logic        req_lock[2];
  logic [4:0]  req_adr [2];
  logic [31:0] req_dat [2];
  logic [3:0]  req_sel [2];
  logic        rsp_ack [2];
  logic        rsp_err [2];

  assign m0_if.cyc   = req_cyc[0];
  assign m0_if.stb   = req_stb[0];
  assign m0_if.we    = req_we[0];
  assign m0_if.lock  = req_lock[0];
  assign m0_if.adr   = req_adr[0];
  assign m0_if.dat_w = req_dat[0];
  assign m0_if.sel   = req_sel[0];
  assign m1_if.cyc   = req_cyc[1];
  assign m1_if.stb   = req_stb[1];
  assign m1_if.we    = req_we[1];
  assign m1_if.lock  = req_lock[1];
  assign m1_if.adr   = req_adr[1];
  assign m1_if.dat_w = req_dat[1];
  assign m1_if.sel   = req_sel[1];
  assign rsp_ack[0]  = m0_if.ack;
  assign rsp_err[0]  = m0_if.err;
  assign rsp_ack[1]  = m1_if.ack;
  assign rsp_err[1]  = m1_if.err;

  logic        stub_ack;
  logic        stub_err;
  logic [31:0] stub_dat;
  int          stub_mode;   // 0 ack, 1 never respond, 2 respond with err
  int          fixed_lat;   // -1 random 0..3, else fixed latency in cycles
  int          stub_wait;
  logic        stub_active;

  assign s_if.ack   = stub_ack;
  assign s_if.err   = stub_err;
  assign s_if.dat_r = stub_dat;

  // Slave stub: answers a beat L cycles after stb first appears (L=0 same cycle).
  always @(posedge clk) begin
    #2;
    if (!s_if.stb) begin
      stub_active = 1'b0;
      stub_ack    = 1'b0;
      stub_err    = 1'b0;
    end else begin
      if (!stub_active) begin
        stub_active = 1'b1;
        stub_wait   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else begin
        stub_wait = stub_wait - 1;
      end
      stub_ack = 1'b0;
      stub_err = 1'b0;
      if (stub_wait == 0 && stub_mode != 1) begin
        if (stub_mode == 2) stub_err = 1'b1;
        else                stub_ack = 1'b1;
        stub_dat = $urandom;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            vectors    = 0;
  int            miscompares = 0;
  int            err_cnt    = 0;
  logic          model_last;

  logic        fr_we [2][8];
  logic [4:0]  fr_adr[2][8];
  logic [31:0] fr_dat[2][8];
  logic [3:0]  fr_sel[2][8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every beat the core ends must be the next expected one, and the
  // response must reach the owner only.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    logic          own;
    logic [3:0]    rsp_exp;
    if (!reset && s_if.stb && (s_if.ack || s_if.err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {s_if.adr, s_if.dat_w}, 64'h0);
        if ({s_if.adr, s_if.dat_w} == 37'h0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got beat expected none at %0t", $time);
        end
      end else begin
        exp = exp_q.pop_front();
        own = exp[EW-1];
        got = {(m1_if.ack | m1_if.err), s_if.we, s_if.adr, s_if.dat_w, s_if.sel};
        chk("beat_owner_fields", got, exp);
        rsp_exp = own ? {2'b00, s_if.ack, s_if.err} : {s_if.ack, s_if.err, 2'b00};
        chk("rsp_routing", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, rsp_exp);
        chk("read_data", own ? m1_if.dat_r : m0_if.dat_r, stub_dat);
      end
    end
  end

  always @(negedge clk) if (m0_if.err || m1_if.err) err_cnt++;

  // ---------------- drivers ----------------
  task automatic set_beat(input int p, input int k, input logic we, input logic [4:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    fr_we[p][k]  = we;
    fr_adr[p][k] = adr;
    fr_dat[p][k] = dat;
    fr_sel[p][k] = sel;
  endtask

  task automatic rand_frame(input int p, input int n);
    for (int k = 0; k < n; k++)
      set_beat(p, k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               4'($urandom_range(0, 15)));
  endtask

  task automatic push_frame(input int p, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({1'(p), fr_we[p][k], fr_adr[p][k], fr_dat[p][k], fr_sel[p][k]});
  endtask

  // Called at posedge+1; leaves at posedge+1 with cyc, stb and lock low.
  task automatic do_frame(input int p, input int n, input int dly);
    int cnt;
    repeat (dly) begin @(posedge clk); #1; end
    for (int k = 0; k < n; k++) begin
      req_we[p]   = fr_we[p][k];
      req_adr[p]  = fr_adr[p][k];
      req_dat[p]  = fr_dat[p][k];
      req_sel[p]  = fr_sel[p][k];
      req_lock[p] = (n > 1);
      req_cyc[p]  = 1'b1;
      req_stb[p]  = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!(rsp_ack[p] || rsp_err[p]) && cnt < 400) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 400) chk("beat_timeout", 64'(cnt), 64'(0));
      @(posedge clk); #1;
      req_cyc[p] = 1'b0;
      req_stb[p] = 1'b0;
      if (k == n - 1) req_lock[p] = 1'b0;
      else begin @(posedge clk); #1; end
    end
  endtask

  // Reference order: the earlier requester wins; a same-cycle tie goes to the
  // port that was not granted last. Locked frames are never split.
  task automatic run_round(input int n0, input int n1, input int d0, input int d1);
    int first;
    if (n0 > 0 && n1 > 0) begin
      if (d0 < d1)      first = 0;
      else if (d1 < d0) first = 1;
      else              first = model_last ? 0 : 1;
      push_frame(first, first ? n1 : n0);
      push_frame(1 - first, first ? n0 : n1);
      model_last = 1'(1 - first);
    end else if (n0 > 0) begin
      push_frame(0, n0);
      model_last = 1'b0;
    end else begin
      push_frame(1, n1);
      model_last = 1'b1;
    end
    fork
      if (n0 > 0) do_frame(0, n0, d0);
      if (n1 > 0) do_frame(1, n1, d1);
    join
  endtask

  task automatic expect_grant(input logic [1:0] g);
    @(negedge clk); chk("grant_before_latency", grant, 2'b00);
    @(negedge clk); chk("grant_after_latency", grant, g);
  endtask

  task automatic idle2();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- sequence ----------------
  initial begin : global_limit
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int k;
    int e0;
    int n0, n1;
    for (int p = 0; p < 2; p++) begin
      req_cyc[p] = 0; req_stb[p] = 0; req_we[p] = 0; req_lock[p] = 0;
      req_adr[p] = 0; req_dat[p] = 0; req_sel[p] = 0;
    end
    stub_ack = 0; stub_err = 0; stub_dat = 0; stub_active = 0; stub_wait = 0;
    stub_mode = 0; fixed_lat = 2;
    model_last = 1'b1;
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_cyc_stb", {s_if.cyc, s_if.stb}, 2'b00);
    chk("rst_s_bus", {s_if.we, s_if.adr, s_if.dat_w, s_if.sel}, 64'h0);
    chk("rst_m_rsp", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle2();

    // Tie after reset: port 0 first, handover two cycles after release
    set_beat(0, 0, 1'b0, 5'h10, 32'h1111_0000, 4'hf);
    set_beat(1, 0, 1'b0, 5'h00, 32'h2222_0000, 4'hf);
    fork
      run_round(1, 1, 0, 0);
      begin
        expect_grant(2'b01);
        cnt = 0;
        while (!m0_if.ack && cnt < 50) begin @(negedge clk); cnt++; end
        chk("tie_m0_acked", m0_if.ack, 1'b1);
        @(negedge clk); chk("release_cycle_grant", grant, 2'b01);
        @(negedge clk); chk("release_idle_grant", grant, 2'b00);
        @(negedge clk); chk("handover_grant", grant, 2'b10);
      end
    join
    idle2();
    // Next tie goes back to port 0
    set_beat(0, 0, 1'b1, 5'h14, 32'h0000_0003, 4'h1);
    set_beat(1, 0, 1'b1, 5'h18, 32'h0000_0001, 4'h1);
    fork
      run_round(1, 1, 0, 0);
      expect_grant(2'b01);
    join
    idle2();

    // Single requester: write divider then read control
    set_beat(0, 0, 1'b1, 5'h14, 32'h0000_0000, 4'hf);
    set_beat(0, 1, 1'b0, 5'h10, 32'h0000_0000, 4'hf);
    fork
      run_round(2, 0, 0, 0);
      begin
        expect_grant(2'b01);
        chk("single_s_fields", {s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.dat_w, s_if.sel},
            {3'b111, 5'h14, 32'h0, 4'hf});
        chk("single_m1_quiet", {m1_if.ack, m1_if.err}, 2'b00);
      end
    join
    idle2();

    // Locked chip-select frame with port 1 requesting throughout
    set_beat(0, 0, 1'b1, 5'h18, 32'h0000_0001, 4'hf);
    set_beat(0, 1, 1'b1, 5'h00, 32'h0000_00a5, 4'hf);
    set_beat(0, 2, 1'b1, 5'h10, 32'h0000_0108, 4'hf);
    set_beat(0, 3, 1'b0, 5'h10, 32'h0, 4'hf);
    set_beat(0, 4, 1'b0, 5'h10, 32'h0, 4'hf);
    set_beat(0, 5, 1'b0, 5'h10, 32'h0, 4'hf);
    set_beat(0, 6, 1'b0, 5'h00, 32'h0, 4'hf);
    set_beat(0, 7, 1'b1, 5'h18, 32'h0000_0000, 4'hf);
    set_beat(1, 0, 1'b0, 5'h1c, 32'hdead_beef, 4'hf);
    fixed_lat = -1;
    run_round(8, 1, 0, 1);
    idle2();

    // Watchdog on port 1
    stub_mode = 1;
    req_we[1] = 1'b0; req_adr[1] = 5'h10; req_dat[1] = 32'h0; req_sel[1] = 4'hf;
    req_cyc[1] = 1'b1; req_stb[1] = 1'b1;
    e0 = err_cnt;
    cnt = 0;
    @(negedge clk);
    while (!s_if.stb && cnt < 20) begin @(negedge clk); cnt++; end
    chk("wd_stb_rise", s_if.stb, 1'b1);
    k = 0;
    while (!m1_if.err && k < 100) begin @(negedge clk); k++; end
    chk("wd_err_latency", 64'(k), 64'(TO));
    chk("wd_m0_err_quiet", m0_if.err, 1'b0);
    @(negedge clk);
    chk("wd_stb_dropped", s_if.stb, 1'b0);
    chk("wd_err_single_pulse", err_cnt - e0, 1);
    @(negedge clk);
    chk("wd_abort_bus_quiet", {s_if.cyc, s_if.stb}, 2'b00);
    @(posedge clk); #1;
    req_cyc[1] = 1'b0; req_stb[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wd_idle_after_drop", grant, 2'b00);
    @(posedge clk); #1;
    stub_mode = 0;
    model_last = 1'b1;
    set_beat(0, 0, 1'b0, 5'h00, 32'h0, 4'hf);
    fork
      run_round(1, 0, 0, 0);
      expect_grant(2'b01);
    join
    idle2();

    // Ack in the cycle the watchdog would fire wins
    fixed_lat = TO - 1;
    e0 = err_cnt;
    set_beat(0, 0, 1'b0, 5'h10, 32'h0, 4'hf);
    run_round(1, 0, 0, 0);
    chk("ack_wins_no_err", err_cnt - e0, 0);
    fixed_lat = 2;
    idle2();

    // Reset while port 1 owns the core with stb high
    stub_mode = 1;
    req_we[1] = 1'b1; req_adr[1] = 5'h18; req_dat[1] = 32'h1; req_sel[1] = 4'hf;
    req_cyc[1] = 1'b1; req_stb[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_owner", {grant, s_if.stb}, {2'b10, 1'b1});
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_cyc[1] = 1'b0; req_stb[1] = 1'b0;
    @(negedge clk);
    chk("post_reset_bus", {grant, s_if.cyc, s_if.stb}, 4'b0000);
    @(posedge clk); #1;
    stub_mode = 0;
    model_last = 1'b1;
    set_beat(0, 0, 1'b0, 5'h04, 32'h0, 4'h3);
    set_beat(1, 0, 1'b0, 5'h08, 32'h0, 4'hc);
    fork
      run_round(1, 1, 0, 0);
      expect_grant(2'b01);
    join
    idle2();

    // Core error passes through without aborting
    stub_mode = 2;
    fixed_lat = 1;
    set_beat(0, 0, 1'b0, 5'h10, 32'h0, 4'hf);
    set_beat(0, 1, 1'b0, 5'h00, 32'h0, 4'hf);
    fork
      run_round(2, 0, 0, 0);
      begin
        cnt = 0;
        @(negedge clk);
        while (!m0_if.err && cnt < 50) begin @(negedge clk); cnt++; end
        chk("err_pass_same_cycle", {m0_if.err, m0_if.ack, grant}, {2'b10, 2'b01});
        @(negedge clk); chk("err_grant_held_1", grant, 2'b01);
        @(negedge clk); chk("err_grant_held_2", grant, 2'b01);
      end
    join
    stub_mode = 0;
    fixed_lat = -1;
    idle2();

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      if (n0 == 0 && n1 == 0) n0 = 1;
      rand_frame(0, n0);
      rand_frame(1, n1);
      run_round(n0, n1, $urandom_range(0, 2), $urandom_range(0, 2));
      idle2();
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
